spi_regfile: RTL

Parametrised SPI-slave register file; successor to the fixed two-register `spi_device`/`spi_register` pair. All SPI pins are sampled in the `wb_clk_i` domain. The block decodes read and write frames and holds `NUM_REGS` registers of `REG_WIDTH` bits. Outputs drive user IO pads or core logic inside `user_project_wrapper`.

---
 rtl/spi_regfile.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_regfile.sv
// SPI-slave register file; every SPI pin is oversampled and edge-detected in the wb_clk_i domain.
// Define SPI_REGFILE_AUTOINC_EN to accept burst frames with an auto-incrementing address.
module spi_regfile #(
    parameter int unsigned          REG_WIDTH  = 8,
    parameter int unsigned          ADDR_WIDTH = 2,
    parameter int unsigned          NUM_REGS   = 4,
    parameter logic [REG_WIDTH-1:0] RESET_VAL  = '0,
    parameter bit                   CPOL       = 1'b0
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          spi_sel_i,
    input  logic                          spi_clk_i,
    input  logic                          spi_mosi_i,
    output logic                          spi_miso_o,
    output logic                          spi_miso_oeb_o,
    output logic [NUM_REGS*REG_WIDTH-1:0] reg_data_o,
    output logic [NUM_REGS-1:0]           reg_wr_stb_o,
    output logic                          frame_err_o
);

    localparam int CW = $clog2(REG_WIDTH + ADDR_WIDTH + 2);

    typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, DRAIN} state_t;
    state_t state, state_next;

    logic [2:0]            sel_sync, clk_sync;
    logic [1:0]            mosi_sync;
    logic                  mosi_q, sel_fall, sel_rise, lead, trail;
    logic [CW-1:0]         bit_cnt;
    logic [ADDR_WIDTH-1:0] cmd_sr, addr_q;
    logic [ADDR_WIDTH:0]   cmd_next;
    logic [REG_WIDTH-2:0]  din_sr;
    logic [REG_WIDTH-1:0]  din_next, miso_sr, rd_cur;
    logic                  rw_q, first_trail, burst_q;
    logic                  last_cmd, last_data, commit, abort;
    logic [REG_WIDTH-1:0]  regs [NUM_REGS];

    // Sel sync flops reset low so a sel already low at reset release never looks like a fall.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sel_sync  <= '0;
            clk_sync  <= {3{CPOL}};
            mosi_sync <= '0;
            mosi_q    <= 1'b0;
            sel_fall  <= 1'b0;
            sel_rise  <= 1'b0;
            lead      <= 1'b0;
            trail     <= 1'b0;
        end else begin
            sel_sync  <= {sel_sync[1:0], spi_sel_i};
            clk_sync  <= {clk_sync[1:0], spi_clk_i};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};
            mosi_q    <= mosi_sync[1];
            sel_fall  <= sel_sync[2] & ~sel_sync[1];
            sel_rise  <= ~sel_sync[2] & sel_sync[1];
            lead      <= CPOL ? (clk_sync[2] & ~clk_sync[1]) : (~clk_sync[2] & clk_sync[1]);
            trail     <= CPOL ? (~clk_sync[2] & clk_sync[1]) : (clk_sync[2] & ~clk_sync[1]);
        end
    end

    assign cmd_next  = {cmd_sr, mosi_q};
    assign din_next  = {din_sr, mosi_q};
    assign last_cmd  = (bit_cnt == CW'(ADDR_WIDTH));
    assign last_data = (bit_cnt == CW'(REG_WIDTH - 1));

    always_comb begin
        rd_cur = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (addr_q == ADDR_WIDTH'(k)) rd_cur = regs[k];
        end
    end

`ifdef SPI_REGFILE_AUTOINC_EN
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [REG_WIDTH-1:0]  rd_inc;

    assign addr_inc = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + 1'b1;

    always_comb begin
        rd_inc = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (addr_inc == ADDR_WIDTH'(k)) rd_inc = regs[k];
        end
    end
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    // A final data bit seen together with sel rise still commits; the frame then ends cleanly.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: if (sel_fall) state_next = CMD;
            CMD: begin
                if (sel_rise) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (lead && last_cmd) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (lead && last_data) begin
                    commit     = 1'b1;
                    state_next = sel_rise ? IDLE : DONE;
                end else if (sel_rise) begin
                    state_next = IDLE;
                    abort      = (bit_cnt != '0) || !burst_q;
                end
            end
            DONE: begin
                if (sel_rise) state_next = IDLE;
                else begin
`ifdef SPI_REGFILE_AUTOINC_EN
                    state_next = DATA;
`else
                    state_next = DRAIN;
`endif
                end
            end
            DRAIN:   if (sel_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // reg_wr_stb_o and frame_err_o are single-cycle pulses; there is no back-pressure.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < int'(NUM_REGS); k++) regs[k] <= RESET_VAL;
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            din_sr       <= '0;
            miso_sr      <= '0;
            first_trail  <= 1'b0;
            burst_q      <= 1'b0;
            reg_wr_stb_o <= '0;
            frame_err_o  <= 1'b0;
        end else begin
            reg_wr_stb_o <= '0;
            frame_err_o  <= abort;
            case (state)
                IDLE: begin
                    if (sel_fall) begin
                        bit_cnt <= '0;
                        burst_q <= 1'b0;
                        miso_sr <= '0;
                    end
                end
                CMD: begin
                    if (lead) begin
                        cmd_sr  <= cmd_next[ADDR_WIDTH-1:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_cmd) begin
                            rw_q        <= cmd_next[ADDR_WIDTH];
                            addr_q      <= cmd_next[ADDR_WIDTH-1:0];
                            bit_cnt     <= '0;
                            first_trail <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (lead) begin
                        din_sr  <= din_next[REG_WIDTH-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    // First trailing edge of a word presents the MSB; later ones shift.
                    if (trail) begin
                        if (first_trail) begin
                            miso_sr     <= rd_cur;
                            first_trail <= 1'b0;
                        end else begin
                            miso_sr <= {miso_sr[REG_WIDTH-2:0], 1'b0};
                        end
                    end
                    if (commit && rw_q) begin
                        for (int k = 0; k < int'(NUM_REGS); k++) begin
                            if (addr_q == ADDR_WIDTH'(k)) begin
                                regs[k]         <= din_next;
                                reg_wr_stb_o[k] <= 1'b1;
                            end
                        end
                    end
                end
`ifdef SPI_REGFILE_AUTOINC_EN
                DONE: begin
                    if (!sel_rise) begin
                        addr_q      <= addr_inc;
                        bit_cnt     <= '0;
                        burst_q     <= 1'b1;
                        miso_sr     <= rd_inc;
                        first_trail <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign reg_data_o[k*REG_WIDTH +: REG_WIDTH] = regs[k];
    end

    assign spi_miso_o     = (state == DATA && !rw_q) ? miso_sr[REG_WIDTH-1] : 1'b0;
    assign spi_miso_oeb_o = (state == IDLE);

endmodule
